// File: rtl/spi_master_core.sv
// SPI mode-0 master engine: runs one transaction of `len` bits per accepted `work`.
// It pulls transmit bytes from a TX FIFO and pushes received bytes into an RX FIFO.
`timescale 1ns/1ps
module spi_master_core #(
  parameter int DATA    = 8,
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     len,
  input  logic            op,
  input  logic            work,
  output logic            busy,
  input  logic [DATA-1:0] tx_rdata,
  output logic            tx_rd,
  input  logic            tx_empty,
  output logic [DATA-1:0] rx_wdata,
  output logic            rx_wr,
  input  logic            rx_full,
  output logic            spi_sclk,
  output logic            spi_mosi,
  input  logic            spi_miso,
  output logic            spi_cs_n
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CW = $clog2(DATA + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BYTE_LAST = CW'(DATA - 1);
  localparam logic [CW-1:0] BYTE_BITS = CW'(DATA);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETUP  = 3'd2,
    S_HIGH   = 3'd3,
    S_LOW    = 3'd4,
    S_PUSH   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [DW-1:0]   div_r;
  logic [15:0]     rem_r;
  logic            op_r, first_r;
  logic [CW-1:0]   bit_cnt_r;
  logic [DATA-1:0] tx_sh_r, rx_sh_r;
  logic            sclk_r, mosi_r, cs_n_r, busy_r, tx_rd_r, rx_wr_r;
  logic [DATA-1:0] rx_wdata_r;
  logic            sclk_nxt_s, mosi_nxt_s, cs_n_nxt_s, busy_nxt_s, tx_rd_nxt_s, rx_wr_nxt_s;
  logic [DATA-1:0] rx_wdata_nxt_s;
  logic            accept_s, div_done_s, load_ok_s, push_ok_s, byte_end_s, last_bit_s;

  assign accept_s   = work && (len != 16'd0);
  assign div_done_s = (div_r == DIV_LAST);
  assign load_ok_s  = !(op_r && tx_empty);
  assign push_ok_s  = op_r || !rx_full;
  assign byte_end_s = (bit_cnt_r == BYTE_LAST);
  assign last_bit_s = (rem_r == 16'd1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:   if (accept_s) state_nxt_s = S_LOAD; else state_nxt_s = S_IDLE;
      S_LOAD:   if (load_ok_s) state_nxt_s = first_r ? S_SETUP : S_LOW; else state_nxt_s = S_LOAD;
      S_SETUP:  if (div_done_s) state_nxt_s = S_HIGH; else state_nxt_s = S_SETUP;
      S_HIGH: begin
        if (div_done_s) state_nxt_s = (last_bit_s || byte_end_s) ? S_PUSH : S_LOW;
        else            state_nxt_s = S_HIGH;
      end
      S_LOW:    if (div_done_s) state_nxt_s = S_HIGH; else state_nxt_s = S_LOW;
      S_PUSH: begin
        if (push_ok_s) state_nxt_s = (rem_r == 16'd0) ? S_FINISH : S_LOAD;
        else           state_nxt_s = S_PUSH;
      end
      S_FINISH: if (div_done_s) state_nxt_s = S_IDLE; else state_nxt_s = S_FINISH;
      default:  state_nxt_s = S_IDLE;
    endcase
  end

  // Next values of the registered pin and FIFO-strobe outputs
  always_comb begin
    sclk_nxt_s     = sclk_r;
    mosi_nxt_s     = mosi_r;
    cs_n_nxt_s     = cs_n_r;
    busy_nxt_s     = busy_r;
    tx_rd_nxt_s    = 1'b0;
    rx_wr_nxt_s    = 1'b0;
    rx_wdata_nxt_s = rx_wdata_r;
    case (state_r)
      S_IDLE: if (accept_s) busy_nxt_s = 1'b1; else busy_nxt_s = busy_r;
      S_LOAD: begin
        if (load_ok_s) begin
          tx_rd_nxt_s = !tx_empty;
          mosi_nxt_s  = !tx_empty && tx_rdata[DATA-1];
          cs_n_nxt_s  = first_r ? 1'b0 : cs_n_r;
        end else begin
          tx_rd_nxt_s = 1'b0;
        end
      end
      S_SETUP, S_LOW: if (div_done_s) sclk_nxt_s = 1'b1; else sclk_nxt_s = sclk_r;
      S_HIGH: begin
        // MOSI moves on the falling edge only when another bit of this byte follows
        if (div_done_s) begin
          sclk_nxt_s = 1'b0;
          mosi_nxt_s = (last_bit_s || byte_end_s) ? mosi_r : tx_sh_r[DATA-1];
        end else begin
          sclk_nxt_s = sclk_r;
        end
      end
      S_PUSH: begin
        if (push_ok_s && !op_r) begin
          rx_wr_nxt_s    = 1'b1;
          rx_wdata_nxt_s = rx_sh_r << (BYTE_BITS - bit_cnt_r);
        end else begin
          rx_wr_nxt_s = 1'b0;
        end
      end
      S_FINISH: begin
        if (div_done_s) begin
          cs_n_nxt_s = 1'b1;
          busy_nxt_s = 1'b0;
          mosi_nxt_s = 1'b0;
        end else begin
          cs_n_nxt_s = cs_n_r;
        end
      end
      default: busy_nxt_s = busy_r;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_r     <= 1'b0;
      mosi_r     <= 1'b0;
      cs_n_r     <= 1'b1;
      busy_r     <= 1'b0;
      tx_rd_r    <= 1'b0;
      rx_wr_r    <= 1'b0;
      rx_wdata_r <= {DATA{1'b0}};
    end else begin
      sclk_r     <= sclk_nxt_s;
      mosi_r     <= mosi_nxt_s;
      cs_n_r     <= cs_n_nxt_s;
      busy_r     <= busy_nxt_s;
      tx_rd_r    <= tx_rd_nxt_s;
      rx_wr_r    <= rx_wr_nxt_s;
      rx_wdata_r <= rx_wdata_nxt_s;
    end
  end

  // Divider, bit counters and shift registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r     <= {DW{1'b0}};
      rem_r     <= 16'd0;
      op_r      <= 1'b0;
      first_r   <= 1'b0;
      bit_cnt_r <= {CW{1'b0}};
      tx_sh_r   <= {DATA{1'b0}};
      rx_sh_r   <= {DATA{1'b0}};
    end else begin
      if (state_nxt_s != state_r) div_r <= {DW{1'b0}};
      else                        div_r <= div_r + DW'(1);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            rem_r   <= len;
            op_r    <= op;
            first_r <= 1'b1;
          end
        end
        S_LOAD: begin
          // MSB already goes straight to MOSI, so keep the remaining bits pre-shifted
          if (load_ok_s) begin
            tx_sh_r   <= tx_empty ? {DATA{1'b0}} : {tx_rdata[DATA-2:0], 1'b0};
            rx_sh_r   <= {DATA{1'b0}};
            bit_cnt_r <= {CW{1'b0}};
            first_r   <= 1'b0;
          end
        end
        S_SETUP, S_LOW: if (div_done_s) rx_sh_r <= {rx_sh_r[DATA-2:0], spi_miso};
        S_HIGH: begin
          if (div_done_s) begin
            rem_r     <= rem_r - 16'd1;
            bit_cnt_r <= bit_cnt_r + CW'(1);
            tx_sh_r   <= {tx_sh_r[DATA-2:0], 1'b0};
          end
        end
        default: first_r <= first_r;
      endcase
    end
  end

  assign spi_sclk = sclk_r;
  assign spi_mosi = mosi_r;
  assign spi_cs_n = cs_n_r;
  assign busy     = busy_r;
  assign tx_rd    = tx_rd_r;
  assign rx_wr    = rx_wr_r;
  assign rx_wdata = rx_wdata_r;

endmodule

// File: tb/tb_spi_master_core.sv
// Self-checking bench for spi_master_core: table of full transactions plus
// hand-written starvation, backpressure and reset/ignored-start sequences.
`timescale 1ns/1ps
module tb_spi_master_core;
  localparam int DATA    = 8;
  localparam int CLK_DIV = 2;
  localparam int PERIOD  = 10;
  localparam int LIMIT   = 5000;

  typedef struct {
    logic [15:0] len;
    logic        op;
    int          ntx;
    logic [39:0] tx_bytes;
    logic [63:0] miso;
    int          exp_rises;
    int          exp_pops;
    int          exp_pushes;
    logic [63:0] exp_mosi;
    logic [39:0] exp_rx;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [15:0]     len = 16'd0;
  logic            op = 1'b0;
  logic            work = 1'b0;
  logic            rx_full = 1'b0;
  logic            busy, tx_rd, tx_empty, rx_wr, spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic [DATA-1:0] tx_rdata, rx_wdata;

  spi_master_core #(.DATA(DATA), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .len(len), .op(op), .work(work), .busy(busy),
    .tx_rdata(tx_rdata), .tx_rd(tx_rd), .tx_empty(tx_empty),
    .rx_wdata(rx_wdata), .rx_wr(rx_wr), .rx_full(rx_full),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #(PERIOD/2) clk = ~clk;

  // TX FIFO model (first-word-fall-through)
  logic [7:0] tx_mem [256];
  logic [7:0] tx_wp = 8'd0;
  logic [7:0] tx_rp = 8'd0;
  int pops = 0;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_rdata = tx_mem[tx_rp];
  always @(posedge clk) if (tx_rd) begin tx_rp <= tx_rp + 8'd1; pops <= pops + 1; end

  logic [7:0] rx_log [256];
  int pushes = 0;
  always @(posedge clk) if (rx_wr) begin rx_log[pushes[7:0]] <= rx_wdata; pushes <= pushes + 1; end

  // Bus observers
  int rises = 0, falls = 0, cs_falls = 0, seen_fall = 0, viol = 0;
  logic [63:0] mosi_sh = 64'd0;
  time cs_fall_t = 0, first_rise_t = 0;
  always @(posedge spi_sclk) begin
    rises   <= rises + 1;
    mosi_sh <= {mosi_sh[62:0], spi_mosi};
    if (seen_fall != cs_falls) begin first_rise_t <= $time; seen_fall <= cs_falls; end
  end
  always @(negedge spi_sclk) falls <= falls + 1;
  always @(negedge spi_cs_n) begin cs_falls <= cs_falls + 1; cs_fall_t <= $time; end

  logic prev_sclk = 1'b0, prev_mosi = 1'b0, prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst && ((spi_sclk && prev_sclk && (spi_mosi != prev_mosi)) ||
                (spi_sclk && spi_cs_n) || (prev_busy && !busy && !spi_cs_n)))
      viol <= viol + 1;
    prev_sclk <= spi_sclk;
    prev_mosi <= spi_mosi;
    prev_busy <= busy;
  end

  // Slave: MISO presents the next bit after each SCLK fall
  logic [63:0] slave_data = 64'd0;
  int fall_base = 0;
  logic [5:0] miso_idx;
  assign miso_idx = 6'd63 - 6'(falls - fall_base);
  assign spi_miso = slave_data[miso_idx];

  int checks = 0, errors = 0;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_mem[tx_wp] = b;
    tx_wp = tx_wp + 8'd1;
  endtask

  task automatic start(input logic [15:0] l, input logic o);
    @(negedge clk); len = l; op = o; work = 1'b1;
    @(negedge clk); work = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c = 0;
    while (busy !== 1'b0 && c < LIMIT) begin @(negedge clk); c++; end
    chk({name, "_done"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_rises(input string name, input int base, input int n);
    int c = 0;
    while ((rises - base) < n && c < LIMIT) begin @(negedge clk); c++; end
    chk({name, "_reach_rises"}, rises - base, n);
  endtask

  task automatic wait_sclk(input string name, input logic v);
    int c = 0;
    while (spi_sclk !== v && c < LIMIT) begin @(negedge clk); c++; end
    chk({name, "_sclk_level"}, {63'd0, spi_sclk}, {63'd0, v});
  endtask

  initial begin
    int b_rise, b_pop, b_push, b_cs, b_viol, bad;
    logic [63:0] mask;

    //        len     op    ntx tx_bytes        miso                    rises pops push mosi            rx
    vecs[0] = '{16'd40, 1'b1, 5, 40'h0019040FA0, 64'h0,                 40,   5,   0,   64'h0019040FA0, 40'h0};
    vecs[1] = '{16'd40, 1'b0, 3, 40'h0019000000, 64'hFFFFFF1234000000,  40,   3,   5,   64'h0019000000, 40'hFFFFFF1234};
    vecs[2] = '{16'd12, 1'b0, 0, 40'h0,          64'hFFFFFFFFFFFFFFFF,  12,   0,   2,   64'h0,          40'hFFF0000000};
    vecs[3] = '{16'd1,  1'b1, 1, 40'hA500000000, 64'h0,                 1,    1,   0,   64'h1,          40'h0};
    vecs[4] = '{16'd9,  1'b0, 2, 40'h3C80000000, 64'hA5C0000000000000,  9,    2,   2,   64'h079,        40'hA580000000};

    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cs_n", {63'd0, spi_cs_n}, 64'd1);
    chk("rst_sclk", {63'd0, spi_sclk}, 64'd0);
    chk("rst_mosi", {63'd0, spi_mosi}, 64'd0);
    chk("rst_strobes", {62'd0, tx_rd, rx_wr}, 64'd0);
    chk("rst_rx_wdata", {56'd0, rx_wdata}, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].ntx; k++) push_tx(vecs[i].tx_bytes[39-8*k -: 8]);
      slave_data = vecs[i].miso;
      fall_base = falls;
      b_rise = rises; b_pop = pops; b_push = pushes; b_cs = cs_falls; b_viol = viol;
      start(vecs[i].len, vecs[i].op);
      wait_idle($sformatf("v%0d", i));
      mask = (64'd1 << vecs[i].len) - 64'd1;
      chk($sformatf("v%0d_rises", i), rises - b_rise, vecs[i].exp_rises);
      chk($sformatf("v%0d_pops", i), pops - b_pop, vecs[i].exp_pops);
      chk($sformatf("v%0d_pushes", i), pushes - b_push, vecs[i].exp_pushes);
      chk($sformatf("v%0d_mosi", i), mosi_sh & mask, vecs[i].exp_mosi);
      for (int k = 0; k < vecs[i].exp_pushes; k++)
        chk($sformatf("v%0d_rx%0d", i, k), {56'd0, rx_log[8'(b_push + k)]}, {56'd0, vecs[i].exp_rx[39-8*k -: 8]});
      chk($sformatf("v%0d_cs_falls", i), cs_falls - b_cs, 1);
      chk($sformatf("v%0d_setup_gap", i), first_rise_t - cs_fall_t, CLK_DIV * PERIOD);
      chk($sformatf("v%0d_protocol", i), viol - b_viol, 0);
      chk($sformatf("v%0d_cs_n_end", i), {63'd0, spi_cs_n}, 64'd1);
      repeat (2) @(negedge clk);
    end

    // TX starvation: second byte arrives 20 cycles late
    push_tx(8'hC3);
    b_rise = rises; b_pop = pops; b_cs = cs_falls; b_viol = viol; bad = 0;
    start(16'd16, 1'b1);
    wait_rises("starve", b_rise, 8);
    wait_sclk("starve", 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0) bad++;
    end
    chk("starve_hold", bad, 0);
    chk("starve_no_rise", rises - b_rise, 8);
    push_tx(8'h5A);
    wait_idle("starve");
    chk("starve_rises", rises - b_rise, 16);
    chk("starve_mosi", mosi_sh & 64'hFFFF, 64'hC35A);
    chk("starve_pops", pops - b_pop, 2);
    chk("starve_cs_falls", cs_falls - b_cs, 1);
    chk("starve_protocol", viol - b_viol, 0);

    // RX backpressure at the first byte boundary
    slave_data = 64'h9C3E000000000000;
    fall_base = falls;
    b_rise = rises; b_push = pushes; b_viol = viol; bad = 0;
    start(16'd16, 1'b0);
    wait_rises("bp", b_rise, 8);
    rx_full = 1'b1;
    wait_sclk("bp", 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b0 || pushes != b_push) bad++;
    end
    chk("bp_hold", bad, 0);
    rx_full = 1'b0;
    wait_idle("bp");
    chk("bp_rises", rises - b_rise, 16);
    chk("bp_pushes", pushes - b_push, 2);
    chk("bp_rx0", {56'd0, rx_log[8'(b_push)]}, 64'h9C);
    chk("bp_rx1", {56'd0, rx_log[8'(b_push + 1)]}, 64'h3E);
    chk("bp_protocol", viol - b_viol, 0);

    // Asynchronous reset mid-byte
    push_tx(8'hAA);
    push_tx(8'h55);
    b_rise = rises;
    start(16'd16, 1'b1);
    wait_rises("rst", b_rise, 3);
    wait_sclk("rst", 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("arst_cs_n", {63'd0, spi_cs_n}, 64'd1);
    chk("arst_sclk", {63'd0, spi_sclk}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    b_pop = pops; b_push = pushes;
    repeat (3) @(negedge clk);
    chk("arst_no_strobes", (pops - b_pop) + (pushes - b_push), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length start is ignored
    b_cs = cs_falls;
    start(16'd0, 1'b1);
    repeat (5) @(negedge clk);
    chk("len0_busy", {63'd0, busy}, 64'd0);
    chk("len0_cs_falls", cs_falls - b_cs, 0);

    // Start while busy is ignored
    b_rise = rises; b_pop = pops; b_cs = cs_falls;
    start(16'd8, 1'b1);
    len = 16'd16; op = 1'b0; work = 1'b1;
    repeat (3) @(negedge clk);
    work = 1'b0;
    wait_idle("busy_ign");
    repeat (20) @(negedge clk);
    chk("busy_ign_idle", {63'd0, busy}, 64'd0);
    chk("busy_ign_cs_falls", cs_falls - b_cs, 1);
    chk("busy_ign_rises", rises - b_rise, 8);
    chk("busy_ign_pops", pops - b_pop, 1);
    chk("busy_ign_mosi", mosi_sh & 64'hFF, 64'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- SPI mode-0 master engine that executes one transaction per `work` pulse. `len` (bits) and `op` come from the command FSM.
- Transmit bytes are pulled from the TX FIFO the command FSM fills. Received bytes are pushed into the RX FIFO the command FSM drains.
- `busy` reports activity back to the command FSM. Sits between the command FSM and the board-level SPI pins.

Parameters:
- DATA, 8, FIFO word width and SPI shift-register width in bits.
- CLK_DIV, 4, clk cycles per SCLK half-period (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- len  in  16  transaction length in bits; sampled on work.
- op  in  1  1=write (RX discarded), 0=read (full duplex, RX stored).
- work  in  1  start strobe; honoured only when busy=0.
- busy  out  1  high from the cycle after an accepted work until return to IDLE.
- tx_rdata  in  DATA  TX FIFO head word, first-word-fall-through; valid while tx_empty=0.
- tx_rd  out  1  TX FIFO pop strobe, one cycle per word.
- tx_empty  in  1  TX FIFO empty.
- rx_wdata  out  DATA  RX FIFO write data.
- rx_wr  out  1  RX FIFO push strobe, one cycle per word.
- rx_full  in  1  RX FIFO full.
- spi_sclk  out  1  SPI clock, idle low.
- spi_mosi  out  1  serial out, MSB first.
- spi_miso  in  1  serial in, sampled on SCLK rising edge.
- spi_cs_n  out  1  chip select, active low.

Behaviour:
- Reset (rst=0, async):
  - State IDLE; busy=0, tx_rd=0, rx_wr=0, rx_wdata=0.
  - spi_sclk=0, spi_mosi=0, spi_cs_n=1; bit and divider counters cleared.
  - Reset mid-transaction aborts immediately: cs_n high on assertion, no further FIFO strobes.
- IDLE:
  - On work=1 with len≠0: latch len/op, busy←1, go LOAD.
  - work with len=0 is ignored. work while busy=1 is ignored.
- LOAD (fetch byte):
  - op=1 and tx_empty=1: stall in LOAD, SCLK held low, cs_n unchanged.
  - op=1 and tx_empty=0: shift reg←tx_rdata, tx_rd pulse 1 cycle.
  - op=0 and tx_empty=0: same as op=1.
  - op=0 and tx_empty=1: shift reg←0, no pop (dummy byte, no stall).
  - Then go SETUP for the first byte, LOW for later bytes.
- SETUP: cs_n←0, mosi←shift MSB; wait CLK_DIV cycles; go HIGH.
- HIGH:
  - sclk←1; sample miso into RX shift LSB at the rising transition.
  - Wait CLK_DIV cycles. Decrement remaining-bit count. sclk←0.
  - Remaining=0 → PUSH. Byte boundary (8 bits done) → PUSH. Otherwise → LOW.
- LOW: mosi←next bit; wait CLK_DIV cycles; go HIGH.
- PUSH:
  - op=1: skip the push.
  - op=0 and rx_full=1: stall, SCLK low, cs_n held.
  - op=0 and rx_full=0: rx_wdata←RX shift, rx_wr 1 cycle.
  - Partial final byte (len mod 8 = k≠0): received bits left-aligned in rx_wdata[DATA-1 -: k], lower bits 0. Only the top k TX bits are sent.
  - Then remaining≠0 → LOAD; remaining=0 → FINISH.
- FINISH: hold cs_n low CLK_DIV cycles, then cs_n←1, busy←0, go IDLE.
- A new work is accepted the cycle after busy falls.
- Timing:
  - First SCLK rising edge occurs CLK_DIV cycles after cs_n falls.
  - Exactly len rising edges per transaction.
  - MOSI changes only while SCLK=0.
- Bytes popped = ceil(len/8) for op=1; up to that for op=0. Bytes pushed (op=0) = ceil(len/8).
- Stalls extend the SCLK low phase only; no SCLK glitches.

Test Plan:
1. Write burst: CLK_DIV=2; TX FIFO preloaded 00,19,04,0F,A0; len=40, op=1, work pulse.
   - Required: cs_n low for the whole transaction; 40 SCLK rises; MOSI stream 0x0019040FA0 MSB-first.
   - Required: 5 tx_rd pulses, 0 rx_wr; busy falls after cs_n rises.
2. Read burst: TX FIFO preloaded 00,19,00; len=40, op=0; slave drives 0xFFFFFF1234 on MISO.
   - Required: MOSI shows 00,19,00,00,00.
   - Required: 3 tx_rd pulses; 5 rx_wr pulses with data FF,FF,FF,12,34.
3. TX starvation: op=1, len=16, one byte in TX FIFO; push the second byte 20 cycles late.
   - Required: SCLK stays low and cs_n stays low during the wait; 16 rises total; no bit lost.
4. RX backpressure: op=0, len=16; rx_full=1 at the first byte end for 10 cycles.
   - Required: SCLK frozen low; rx_wr fires only once rx_full=0; second byte completes normally.
5. Partial length: op=0, len=12; MISO all 1s.
   - Required: 12 SCLK rises; rx_wdata sequence FF, F0.
6. Reset and ignored starts: assert rst low mid-byte.
   - Required: cs_n=1, sclk=0, busy=0 asynchronously.
   - Required: after release, work with len=0 leaves busy=0; work during busy is ignored (single transaction observed).
